slave_node: RTL and testbench
=============================

# slave_node

Per-channel input node of the multi-channel data formatter: accepts 32-bit words with a parity bit from one external slave channel, checks parity, and buffers good words in a 32-entry FIFO for the downstream arbiter. It consumes `slv_en` and `err_clr` from the register interface. It returns `free_slot` and `parity_err` to the register interface's read-only status registers. Four instances sit between the channel pins and the arbiter, one per slave.

## Interface
- `DEPTH`, 32: FIFO entries; power of two, at most 32.
- `DW`, 32: data word width.
- `clk_i` input 1: clock, all logic rising-edge.
- `rst_i` input 1: reset; synchronous, active-high.
- `slv_en_i` input 1: channel enable from the control register.
- `err_clr_i` input 1: parity-error clear from the control register; level, any cycle.
- `slv_data_i` input DW: incoming word.
- `slv_parity_i` input 1: even-parity bit covering `slv_data_i`.
- `slv_valid_i` input 1: word present on `slv_data_i`.
- `slv_wait_o` output 1: back-pressure; the sender holds the word while this is high.
- `free_slot_o` output 6: empty FIFO entries, range 0..DEPTH.
- `parity_err_o` output 1: sticky parity-error flag.
- `fetch_i` input 1: downstream pop request.
- `data_o` output DW: FIFO head word; 0 when empty.
- `data_valid_o` output 1: FIFO non-empty.

## Operation
- **Accept**: `acc = slv_valid_i & ~slv_wait_o`.
- **Back-pressure**: `slv_wait_o = ~slv_en_i | full`, combinational. When `slv_en_i` is low, the FIFO still drains.
- **Parity check**: a word is good when the XOR over `slv_data_i` and `slv_parity_i` equals 0.
  - Good accepted word: written at `wr_ptr`; `wr_ptr` increments.
  - Bad accepted word: dropped, FIFO unchanged, `parity_err_o` set on the next edge.
- **Pop**: `pop = fetch_i & ~empty`. `fetch_i` while empty is ignored, with no pointer change.
- **Storage**: pointers are log2(DEPTH)+1 bits wide, with wrap bit.
  - `count` is a register, 0..DEPTH.
  - `empty = (count == 0)`; `full = (count == DEPTH)`.
- **Simultaneous push and pop**: `count` is unchanged and both pointers advance.
  - At `count == DEPTH` no push is possible, because wait is high.
  - At `count == 0`, push only; the pop is ignored.
- **Outputs**:
  - `free_slot_o = DEPTH - count`, from the register.
  - `data_o = empty ? 0 : mem[rd_ptr]`.
  - `data_valid_o = ~empty`.
- **Parity-error flag**: set has priority over `err_clr_i` in the same cycle. `err_clr_i` alone clears it on the next edge.
- **Enable drop during a transfer**: if `slv_en_i` drops while `slv_valid_i` is high, wait rises the same cycle, so no accept occurs.
- **Reset values**:
  - Pointers 0, count 0, `parity_err_o` 0.
  - `free_slot_o` = DEPTH, `data_valid_o` 0, `data_o` 0.
  - `slv_wait_o` = `~slv_en_i`.
  - Memory contents are not reset.
- **Reset mid-operation**: empties the FIFO on the reset edge; buffered words are lost.

## Timing
- Accept to `data_valid_o`/`data_o`: 1 cycle (first-word fall-through from the register array).
- Accept or pop to `free_slot_o` update: 1 cycle.
- Bad word to `parity_err_o` high: 1 cycle.
- `err_clr_i` to `parity_err_o` low: 1 cycle.
- Full to `slv_wait_o` high: same cycle `count` reaches DEPTH, i.e. 1 cycle after the filling accept. No accept is lost.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `SLAVE_NODE_PARITY_EN` defined: parity checking, word dropping and the sticky flag as described.
- `SLAVE_NODE_PARITY_EN` undefined:
  - `slv_parity_i` is ignored.
  - Every accepted word is stored.
  - `parity_err_o` is tied 0.
  - `err_clr_i` is unused.

## Structure
- Shared package `mcdf_pkg`:
  - Constants `MCDF_FIFO_DEPTH` = 32 and `MCDF_DW` = 32.
  - Free-slot width constant, 6.
  - Even-parity function `mcdf_parity(data, p)`.
- One sub-module, `mcdf_sync_fifo`:
  - Contains the pointers, count, memory, full/empty and free-slot logic.
  - Parameterised by DEPTH and DW.
- `slave_node` keeps the accept, parity and error-flag logic.

## Test plan
- Reset, `slv_en_i`=0, `slv_valid_i`=1 -> `slv_wait_o`=1, `free_slot_o`=32, `data_valid_o`=0, `data_o`=0, no write.
- Enable; send 0x12345678 with parity 1 (13 ones, odd) -> accepted; next cycle `data_o`=0x12345678, `data_valid_o`=1, `free_slot_o`=31.
- Send 0x00000001 with parity 0 -> dropped; `parity_err_o`=1 next cycle, `free_slot_o` unchanged. Pulse `err_clr_i` together with a second bad word -> flag stays 1. `err_clr_i` alone -> flag 0.
- Push 32 good words with no fetch -> `free_slot_o`=0, `slv_wait_o`=1; the 33rd word is held. One `fetch_i` -> `free_slot_o`=1 next cycle, the held word is accepted, order preserved.
- Continuous push and `fetch_i` at `count`=5 for 100 cycles -> count stays 5, data in order, pointers wrap cleanly.
- `rst_i` asserted at `count`=10 -> next cycle `free_slot_o`=32, `data_valid_o`=0, `parity_err_o`=0.

Source files
------------

// File: rtl/mcdf_pkg.sv
// Shared constants and helpers for the multi-channel data formatter.
// mcdf_parity() returns 0 for a word whose data bits plus parity bit carry even parity.
package mcdf_pkg;

  localparam int MCDF_FIFO_DEPTH = 32;
  localparam int MCDF_DW         = 32;
  localparam int MCDF_FSW        = 6;

  typedef logic [MCDF_DW-1:0] mcdf_word_t;

  function automatic logic mcdf_parity(input mcdf_word_t data, input logic p);
    return (^data) ^ p;
  endfunction

endpackage

// File: rtl/slave_node_if.sv
// Slave channel handshake between the external sender and a slave_node.
// The sender holds data/parity/valid while the node raises slv_wait.
interface slave_node_if
  import mcdf_pkg::*;
#(
  parameter int DW = MCDF_DW
);

  logic [DW-1:0] slv_data;
  logic          slv_parity;
  logic          slv_valid;
  logic          slv_wait;

  modport master (
    output slv_data,
    output slv_parity,
    output slv_valid,
    input  slv_wait
  );

  modport slave (
    input  slv_data,
    input  slv_parity,
    input  slv_valid,
    output slv_wait
  );

endinterface

// File: rtl/mcdf_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and first-word fall-through.
// The head word is read straight from the register array so it is visible the cycle after the write.
module mcdf_sync_fifo
  import mcdf_pkg::*;
#(
  parameter int DEPTH = MCDF_FIFO_DEPTH,
  parameter int DW    = MCDF_DW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_push,
  input  logic [DW-1:0]       i_wdata,
  input  logic                i_pop,
  output logic [DW-1:0]       o_rdata,
  output logic                o_empty,
  output logic                o_full,
  output logic [MCDF_FSW-1:0] o_free_slot
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;
  logic w_unused_wrap;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Wrap bits are kept for pointer debug visibility; occupancy comes from r_count.
  assign w_unused_wrap = r_wr_ptr[AW] ^ r_rd_ptr[AW];

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata     = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_free_slot = MCDF_FSW'(DEPTH) - MCDF_FSW'(r_count);

endmodule

// File: rtl/slave_node.sv
// Per-channel input node: accepts words from one slave channel, optionally checks parity, buffers in a FIFO.
// Optional feature macro SLAVE_NODE_PARITY_EN enables parity dropping and the sticky parity_err_o flag.
module slave_node
  import mcdf_pkg::*;
#(
  parameter int DEPTH = MCDF_FIFO_DEPTH,
  parameter int DW    = MCDF_DW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slv_en_i,
  input  logic                err_clr_i,
  slave_node_if.slave         slv,
  output logic [MCDF_FSW-1:0] free_slot_o,
  output logic                parity_err_o,
  input  logic                fetch_i,
  output logic [DW-1:0]       data_o,
  output logic                data_valid_o
);

  logic w_full;
  logic w_empty;
  logic w_wait;
  logic w_acc;
  logic w_push;

  // Wait rises in the same cycle the enable drops, so no word is accepted while disabled.
  assign w_wait       = ~slv_en_i | w_full;
  assign slv.slv_wait = w_wait;
  assign w_acc        = slv.slv_valid & ~w_wait;

`ifdef SLAVE_NODE_PARITY_EN
  logic w_bad;
  logic r_parity_err;

  assign w_bad  = mcdf_parity(MCDF_DW'(slv.slv_data), slv.slv_parity);
  assign w_push = w_acc & ~w_bad;

  // A new bad word wins over a clear arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_parity_err <= 1'b0;
    end else if (w_acc && w_bad) begin
      r_parity_err <= 1'b1;
    end else if (err_clr_i) begin
      r_parity_err <= 1'b0;
    end
  end

  assign parity_err_o = r_parity_err;
`else
  logic w_unused_parity;

  assign w_push          = w_acc;
  assign parity_err_o    = 1'b0;
  assign w_unused_parity = slv.slv_parity ^ err_clr_i;
`endif

  mcdf_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (w_push),
    .i_wdata     (slv.slv_data),
    .i_pop       (fetch_i),
    .o_rdata     (data_o),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_free_slot (free_slot_o)
  );

  assign data_valid_o = ~w_empty;

endmodule

// File: tb/tb_slave_node.sv
// Self-checking bench for slave_node: queue-based reference model compared every cycle,
// plus directed literal checks; honours SLAVE_NODE_PARITY_EN the same way as the design.
module tb_slave_node;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        slv_en;
  logic        err_clr;
  logic        fetch;
  logic [5:0]  free_slot;
  logic        parity_err;
  logic [31:0] data;
  logic        data_valid;

  slave_node_if #(.DW(32)) slv_if();

  slave_node #(
    .DEPTH (DEPTH),
    .DW    (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_en_i     (slv_en),
    .err_clr_i    (err_clr),
    .slv          (slv_if.slave),
    .free_slot_o  (free_slot),
    .parity_err_o (parity_err),
    .fetch_i      (fetch),
    .data_o       (data),
    .data_valid_o (data_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words and a sticky error bit.
  logic [31:0] mq[$];
  logic        m_err  = 1'b0;
  bit          m_init = 1'b0;

  always @(posedge clk) begin : model
    bit acc;
    bit good;
    bit pop;
    if (rst) begin
      mq.delete();
      m_err  = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      acc = slv_if.slv_valid && slv_en && (mq.size() < DEPTH);
`ifdef SLAVE_NODE_PARITY_EN
      good = ($countones({slv_if.slv_data, slv_if.slv_parity}) % 2) == 0;
`else
      good = 1'b1;
`endif
      pop = fetch && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (acc && good) mq.push_back(slv_if.slv_data);
      if (acc && !good) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    if (m_init) begin
      chk("slv_wait",   32'(slv_if.slv_wait), 32'(!slv_en || mq.size() == DEPTH));
      chk("free_slot",  32'(free_slot),       32'(DEPTH - mq.size()));
      chk("data_valid", 32'(data_valid),      32'(mq.size() != 0));
      chk("data_o",     data,                 (mq.size() != 0) ? mq[0] : 32'h0);
      chk("parity_err", 32'(parity_err),      32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic p);
    int waited;
    waited = 0;
    slv_if.slv_data   = d;
    slv_if.slv_parity = p;
    slv_if.slv_valid  = 1'b1;
    @(negedge clk);
    while (slv_if.slv_wait && waited < 64) begin
      waited++;
      @(negedge clk);
    end
    if (slv_if.slv_wait) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: wait still 1 after %0d cycles, required 0", waited);
    end
    @(posedge clk);
    #1;
    slv_if.slv_valid = 1'b0;
    $display("send data=0x%08h parity=%0b waited=%0d", d, p, waited);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    rst               = 1'b1;
    slv_en            = 1'b0;
    err_clr           = 1'b0;
    fetch             = 1'b0;
    slv_if.slv_valid  = 1'b1;
    slv_if.slv_data   = 32'hDEADBEEF;
    slv_if.slv_parity = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state with enable low and valid high
    @(negedge clk);
    chk("rst_wait", 32'(slv_if.slv_wait), 32'd1);
    chk("rst_free", 32'(free_slot), 32'd32);
    chk("rst_dv",   32'(data_valid), 32'd0);
    chk("rst_data", data, 32'd0);
    step();
    @(negedge clk);
    chk("dis_nowrite_free", 32'(free_slot), 32'd32);
    step();

    // First good word, fall-through next cycle
    slv_if.slv_valid = 1'b0;
    slv_en = 1'b1;
    send(32'h12345678, 1'b1);
    @(negedge clk);
    chk("first_data", data, 32'h12345678);
    chk("first_dv",   32'(data_valid), 32'd1);
    chk("first_free", 32'(free_slot), 32'd31);
    step();

    // Bad word, then clear racing a second bad word, then clear alone
    send(32'h00000001, 1'b0);
    @(negedge clk);
`ifdef SLAVE_NODE_PARITY_EN
    chk("bad_err",  32'(parity_err), 32'd1);
    chk("bad_free", 32'(free_slot), 32'd31);
`else
    chk("bad_err",  32'(parity_err), 32'd0);
    chk("bad_free", 32'(free_slot), 32'd30);
`endif
    step();
    err_clr = 1'b1;
    send(32'h00000003, 1'b1);
    err_clr = 1'b0;
    @(negedge clk);
`ifdef SLAVE_NODE_PARITY_EN
    chk("set_beats_clr", 32'(parity_err), 32'd1);
`else
    chk("set_beats_clr", 32'(free_slot), 32'd29);
`endif
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_alone", 32'(parity_err), 32'd0);
    step();

    // Drain, including fetches while empty
    fetch = 1'b1;
    repeat (5) step();
    fetch = 1'b0;
    @(negedge clk);
    chk("drain_dv",   32'(data_valid), 32'd0);
    chk("drain_free", 32'(free_slot), 32'd32);
    step();

    // Fill to full
    for (int i = 0; i < 32; i++) begin
      d = 32'hA5000000 + 32'(i) * 32'h00010001;
      send(d, ^d);
    end
    @(negedge clk);
    chk("full_free", 32'(free_slot), 32'd0);
    chk("full_wait", 32'(slv_if.slv_wait), 32'd1);
    step();

    // 33rd word held until one slot frees up
    slv_if.slv_data   = 32'hC0FFEE33;
    slv_if.slv_parity = ^slv_if.slv_data;
    slv_if.slv_valid  = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("held_free", 32'(free_slot), 32'd0);
    chk("held_wait", 32'(slv_if.slv_wait), 32'd1);
    step();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    @(negedge clk);
    chk("pop_free", 32'(free_slot), 32'd1);
    chk("pop_wait", 32'(slv_if.slv_wait), 32'd0);
    step();
    slv_if.slv_valid = 1'b0;
    $display("send data=0x%08h parity=%0b waited=4", slv_if.slv_data, slv_if.slv_parity);
    @(negedge clk);
    chk("refill_free", 32'(free_slot), 32'd0);
    chk("refill_head", data, 32'hA5010001);
    step();

    // Drain down to five entries
    fetch = 1'b1;
    repeat (27) step();
    fetch = 1'b0;
    @(negedge clk);
    chk("five_free", 32'(free_slot), 32'd27);
    chk("five_head", data, 32'hA51C001C);
    step();

    // Sustained push and pop at count five
    fetch = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = 32'h5A5A0000 ^ (32'(i) * 32'h01000003);
      send(d, ^d);
    end
    fetch = 1'b0;
    @(negedge clk);
    chk("stream_free", 32'(free_slot), 32'd27);
    step();

    // Reach count ten, then reset mid-operation
`ifdef SLAVE_NODE_PARITY_EN
    send(32'h00000007, 1'b0);
`endif
    for (int i = 0; i < 5; i++) begin
      d = 32'h0F0F0000 + 32'(i);
      send(d, ^d);
    end
    @(negedge clk);
    chk("ten_free", 32'(free_slot), 32'd22);
`ifdef SLAVE_NODE_PARITY_EN
    chk("ten_err", 32'(parity_err), 32'd1);
`endif
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_free", 32'(free_slot), 32'd32);
    chk("mid_rst_dv",   32'(data_valid), 32'd0);
    chk("mid_rst_err",  32'(parity_err), 32'd0);
    chk("mid_rst_data", data, 32'd0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
